// File: rtl/spi_regfile_pkg.sv
// Shared types and helpers for the SPI register file.
// Holds the FSM state encoding, default signatures and frame field extractors.
// Field extractors take widths as arguments so any parametrisation can reuse them.
package spi_regfile_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DECODE = 2'd1,
    RESP   = 2'd2
  } state_t;

  localparam logic [3:0] SIG_WR_DEF = 4'b0110;
  localparam logic [3:0] SIG_RD_DEF = 4'b0111;

  // Low-order mask of the given width
  function automatic logic [63:0] field_mask(input int w);
    return (64'd1 << w) - 64'd1;
  endfunction

  // Frame layout is {sig, addr, data}, MSB first
  function automatic logic [63:0] frame_sig(input logic [63:0] frame, input int sig_w,
                                            input int addr_w, input int data_w);
    return (frame >> (addr_w + data_w)) & field_mask(sig_w);
  endfunction

  function automatic logic [63:0] frame_addr(input logic [63:0] frame, input int addr_w,
                                             input int data_w);
    return (frame >> data_w) & field_mask(addr_w);
  endfunction

  function automatic logic [63:0] frame_data(input logic [63:0] frame, input int data_w);
    return frame & field_mask(data_w);
  endfunction

endpackage

// File: rtl/spi_sat_cnt.sv
// Saturating event counter for link diagnostics.
// One cycle from inc to updated value; holds at all-ones once saturated.
// Synchronous clear has priority over a coincident increment.
module spi_sat_cnt #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             inc,
  input  logic             clr,
  output logic [CNT_W-1:0] value
);

  // Count up until all-ones, clear wins over increment
  always_ff @(posedge clk) begin
    if (rst || clr) begin
      value <= '0;
    end else if (inc && (value != '1)) begin
      value <= value + CNT_W'(1);
    end
  end

endmodule

// File: rtl/spi_regfile.sv
// SPI-slave register file: decodes received frames into register writes or read-backs.
// rx_done at N -> effects visible at N+2; read responses held on tx_valid until tx_ready.
// Frames arriving while not IDLE are dropped and counted; no backpressure toward the receiver.
module spi_regfile
  import spi_regfile_pkg::*;
#(
  parameter int                SIG_W     = 4,
  parameter logic [SIG_W-1:0]  SIG_WR    = SIG_W'(SIG_WR_DEF),
  parameter logic [SIG_W-1:0]  SIG_RD    = SIG_W'(SIG_RD_DEF),
  parameter int                ADDR_W    = 4,
  parameter int                DATA_W    = 8,
  parameter int                NUM_REGS  = 16,
  parameter logic [DATA_W-1:0] RESET_VAL = '0,
  parameter int                CNT_W     = 8,
  parameter int                FRAME_W   = SIG_W + ADDR_W + DATA_W
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       rx_done,
  input  logic [FRAME_W-1:0]         rx_data,
  output logic [NUM_REGS*DATA_W-1:0] regs_flat,
  output logic [NUM_REGS-1:0]        wr_stb,
  output logic                       frame_ok,
  output logic                       frame_err,
  output logic [FRAME_W-1:0]         tx_data,
  output logic                       tx_valid,
  input  logic                       tx_ready,
  output logic                       busy,
  input  logic                       clr_stat,
  output logic [CNT_W-1:0]           sig_err_cnt,
  output logic [CNT_W-1:0]           range_err_cnt,
  output logic [CNT_W-1:0]           drop_cnt
);

  state_t              state_q, state_d;
  logic [FRAME_W-1:0]  frame_q;
  logic [DATA_W-1:0]   regs_q [NUM_REGS];

  logic [63:0]         frame_ext;
  logic [SIG_W-1:0]    f_sig;
  logic [ADDR_W-1:0]   f_addr;
  logic [DATA_W-1:0]   f_data;
  logic [31:0]         addr_u;
  logic                is_wr, is_rd, in_range;

  // Decode actions, valid only while in DECODE
  logic                do_wr, do_rd, dec_ok, dec_err;
  logic                sig_inc, range_inc, drop_inc;
  logic [NUM_REGS-1:0] wr_sel;
  logic [DATA_W-1:0]   rd_val;

  assign frame_ext = 64'(frame_q);
  assign f_sig     = SIG_W'(frame_sig(frame_ext, SIG_W, ADDR_W, DATA_W));
  assign f_addr    = ADDR_W'(frame_addr(frame_ext, ADDR_W, DATA_W));
  assign f_data    = DATA_W'(frame_data(frame_ext, DATA_W));
  assign addr_u    = 32'(f_addr);
  assign is_wr     = (f_sig == SIG_WR);
  assign is_rd     = (f_sig == SIG_RD);
  assign in_range  = (addr_u < 32'(NUM_REGS));

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state: reads (even out of range) always produce a response
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (rx_done) state_d = DECODE;
      DECODE:  state_d = is_rd ? RESP : IDLE;
      RESP:    if (tx_valid && tx_ready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Output decode: per-state actions feeding the registered outputs and counters
  always_comb begin
    busy      = (state_q != IDLE);
    do_wr     = 1'b0;
    do_rd     = 1'b0;
    dec_ok    = 1'b0;
    dec_err   = 1'b0;
    sig_inc   = 1'b0;
    range_inc = 1'b0;
    drop_inc  = rx_done && (state_q != IDLE);
    if (state_q == DECODE) begin
      do_wr     = is_wr && in_range;
      do_rd     = is_rd;
      dec_ok    = (is_wr || is_rd) && in_range;
      dec_err   = !((is_wr || is_rd) && in_range);
      sig_inc   = !(is_wr || is_rd);
      range_inc = (is_wr || is_rd) && !in_range;
    end
  end

  // One-hot write select and read mux; out-of-range reads return zero
  always_comb begin
    wr_sel = '0;
    rd_val = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      wr_sel[i] = do_wr && (addr_u == 32'(i));
      if (in_range && (addr_u == 32'(i))) rd_val = regs_q[i];
    end
  end

  // Frame capture only when idle, so dropped frames leave it untouched
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_q <= '0;
    end else if ((state_q == IDLE) && rx_done) begin
      frame_q <= rx_data;
    end
  end

  // Register bank update
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= RESET_VAL;
    end else begin
      for (int i = 0; i < NUM_REGS; i++) begin
        if (wr_sel[i]) regs_q[i] <= f_data;
      end
    end
  end

  for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
    assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
  end

  // Registered strobes and read response; response held until handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_stb    <= '0;
      frame_ok  <= 1'b0;
      frame_err <= 1'b0;
      tx_valid  <= 1'b0;
      tx_data   <= '0;
    end else begin
      wr_stb    <= wr_sel;
      frame_ok  <= dec_ok;
      frame_err <= dec_err;
      if (do_rd) begin
        tx_data  <= {SIG_RD, f_addr, rd_val};
        tx_valid <= 1'b1;
      end else if (tx_valid && tx_ready) begin
        tx_valid <= 1'b0;
      end
    end
  end

  spi_sat_cnt #(.CNT_W(CNT_W)) u_sig_cnt (
    .clk(clk), .rst(rst), .inc(sig_inc), .clr(clr_stat), .value(sig_err_cnt)
  );

  spi_sat_cnt #(.CNT_W(CNT_W)) u_range_cnt (
    .clk(clk), .rst(rst), .inc(range_inc), .clr(clr_stat), .value(range_err_cnt)
  );

  spi_sat_cnt #(.CNT_W(CNT_W)) u_drop_cnt (
    .clk(clk), .rst(rst), .inc(drop_inc), .clr(clr_stat), .value(drop_cnt)
  );

endmodule

// File: tb/tb_spi_regfile.sv
// Self-checking bench for spi_regfile with 12 registers and 2-bit counters.
// Read responses are checked through a scoreboard queue popped on each handshake.
// Inputs change 1ns after the rising edge; outputs are sampled there or on the falling edge.
module tb_spi_regfile;

  localparam int         NR = 12;
  localparam int         DW = 8;
  localparam int         FW = 16;
  localparam int         CW = 2;
  localparam logic [7:0] RV = 8'h5A;

  logic              clk = 1'b0;
  logic              rst;
  logic              rx_done;
  logic [FW-1:0]     rx_data;
  logic [NR*DW-1:0]  regs_flat;
  logic [NR-1:0]     wr_stb;
  logic              frame_ok, frame_err;
  logic [FW-1:0]     tx_data;
  logic              tx_valid, tx_ready;
  logic              busy;
  logic              clr_stat;
  logic [CW-1:0]     sig_err_cnt, range_err_cnt, drop_cnt;

  always #5 clk = ~clk;

  spi_regfile #(
    .NUM_REGS(NR), .CNT_W(CW), .RESET_VAL(RV)
  ) dut (
    .clk(clk), .rst(rst), .rx_done(rx_done), .rx_data(rx_data),
    .regs_flat(regs_flat), .wr_stb(wr_stb), .frame_ok(frame_ok), .frame_err(frame_err),
    .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready), .busy(busy),
    .clr_stat(clr_stat), .sig_err_cnt(sig_err_cnt), .range_err_cnt(range_err_cnt),
    .drop_cnt(drop_cnt)
  );

  int            n_cmp = 0;
  int            n_bad = 0;
  logic [FW-1:0] exp_q[$];
  logic [DW-1:0] mdl [NR];
  logic [CW-1:0] e_sig, e_rng, e_drop;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [NR*DW-1:0] mdl_flat();
    logic [NR*DW-1:0] f;
    for (int i = 0; i < NR; i++) f[i*DW +: DW] = mdl[i];
    return f;
  endfunction

  function automatic logic [CW-1:0] sat(input logic [CW-1:0] v);
    return (v == '1) ? v : v + CW'(1);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NR; i++) mdl[i] = RV;
    e_sig = '0; e_rng = '0; e_drop = '0;
  endtask

  task automatic chk_counters(input string tag);
    chk({tag, "_sig_cnt"}, sig_err_cnt, e_sig);
    chk({tag, "_rng_cnt"}, range_err_cnt, e_rng);
    chk({tag, "_drop_cnt"}, drop_cnt, e_drop);
  endtask

  // Pulse rx_done for one cycle; returns in the DECODE cycle (N+1)
  task automatic send(input logic [FW-1:0] f);
    rx_data = f;
    rx_done = 1'b1;
    step();
    rx_done = 1'b0;
  endtask

  // Drive one frame from IDLE and check everything the model predicts at N+1, N+2, N+3
  task automatic run_frame(input logic [FW-1:0] f, input string tag);
    logic [3:0]    sg;
    logic [3:0]    ad;
    logic [7:0]    dt;
    logic          wr, rd, inr;
    logic [NR-1:0] stb;
    sg  = f[15:12];
    ad  = f[11:8];
    dt  = f[7:0];
    wr  = (sg == 4'b0110);
    rd  = (sg == 4'b0111);
    inr = (ad < NR);
    if (rd) exp_q.push_back({4'b0111, ad, inr ? mdl[ad] : 8'h00});
    send(f);
    chk({tag, "_busy_n1"}, busy, 1'b1);
    chk({tag, "_ok_n1"}, frame_ok, 1'b0);
    step();
    stb = '0;
    if (wr && inr) begin
      stb[ad] = 1'b1;
      mdl[ad] = dt;
    end
    if (!(wr || rd)) e_sig = sat(e_sig);
    if ((wr || rd) && !inr) e_rng = sat(e_rng);
    chk({tag, "_wr_stb"}, wr_stb, stb);
    chk({tag, "_ok"}, frame_ok, (wr || rd) && inr);
    chk({tag, "_err"}, frame_err, !((wr || rd) && inr));
    chk({tag, "_regs"}, regs_flat, mdl_flat());
    chk({tag, "_tx_valid"}, tx_valid, rd);
    chk({tag, "_busy_n2"}, busy, rd);
    chk_counters(tag);
    step();
    chk({tag, "_wr_stb_n3"}, wr_stb, '0);
    chk({tag, "_ok_n3"}, frame_ok, 1'b0);
    chk({tag, "_err_n3"}, frame_err, 1'b0);
  endtask

  // Accept the pending response; the release must come within a bounded number of cycles
  task automatic complete_tx(input string tag);
    tx_ready = 1'b1;
    for (int i = 0; i < 8 && tx_valid; i++) step();
    chk({tag, "_tx_release"}, tx_valid, 1'b0);
    chk({tag, "_busy_idle"}, busy, 1'b0);
    tx_ready = 1'b0;
  endtask

  // Scoreboard: every handshake must match the oldest expected response
  always @(negedge clk) begin
    if (!rst && tx_valid && tx_ready) begin
      chk("sb_has_entry", exp_q.size() != 0, 1'b1);
      if (exp_q.size() != 0) chk("sb_tx_data", tx_data, exp_q.pop_front());
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [FW-1:0] held;
    rst = 1'b1; rx_done = 1'b0; rx_data = '0; tx_ready = 1'b0; clr_stat = 1'b0;
    mdl_reset();
    step(); step(); step();
    chk("rst_regs", regs_flat, mdl_flat());
    chk("rst_wr_stb", wr_stb, '0);
    chk("rst_ok", frame_ok, 1'b0);
    chk("rst_err", frame_err, 1'b0);
    chk("rst_tx_valid", tx_valid, 1'b0);
    chk("rst_tx_data", tx_data, '0);
    chk("rst_busy", busy, 1'b0);
    chk_counters("rst");
    rst = 1'b0;
    step();

    // Write then read back register 3 with a slow consumer
    run_frame(16'h63A5, "wr3");
    run_frame(16'h7300, "rd3");
    for (int i = 0; i < 5; i++) begin
      chk("rd3_hold_valid", tx_valid, 1'b1);
      chk("rd3_hold_data", tx_data, 16'h73A5);
      chk("rd3_hold_busy", busy, 1'b1);
      step();
    end
    tx_ready = 1'b1;
    chk("rd3_pre_hs_valid", tx_valid, 1'b1);
    step();
    chk("rd3_release", tx_valid, 1'b0);
    tx_ready = 1'b0;
    // Frame in the cycle right after the handshake must be accepted
    run_frame(16'h6B3C, "wr11_b2b");
    chk("b2b_no_drop", drop_cnt, '0);

    // Boundary registers and unwritten register
    run_frame(16'h6011, "wr0");
    run_frame(16'h7B00, "rd11");
    complete_tx("rd11");
    run_frame(16'h7100, "rd1_reset_val");
    complete_tx("rd1");

    // tx_ready with nothing pending has no effect
    tx_ready = 1'b1;
    step();
    chk("idle_ready_valid", tx_valid, 1'b0);
    tx_ready = 1'b0;

    // Bad signature and out-of-range accesses
    run_frame(16'h51FF, "badsig");
    run_frame(16'h6E11, "rng_wr");
    run_frame(16'h6C22, "rng_wr12");
    run_frame(16'h7E00, "rng_rd");
    chk("rng_rd_data", tx_data, 16'h7E00);
    complete_tx("rng_rd");

    // Frame arriving during RESP is dropped; pending response and registers untouched
    run_frame(16'h6577, "wr5");
    run_frame(16'h7500, "rd5");
    held = tx_data;
    send(16'h6512);
    step();
    e_drop = sat(e_drop);
    chk("drop_cnt", drop_cnt, e_drop);
    chk("drop_tx_valid", tx_valid, 1'b1);
    chk("drop_tx_data", tx_data, held);
    chk("drop_regs", regs_flat, mdl_flat());
    chk("drop_no_ok", frame_ok, 1'b0);
    complete_tx("rd5");

    // Reset while a response is pending abandons it
    run_frame(16'h7300, "rd_rst");
    void'(exp_q.pop_back());
    rst = 1'b1;
    step();
    mdl_reset();
    chk("rstresp_tx_valid", tx_valid, 1'b0);
    chk("rstresp_tx_data", tx_data, '0);
    chk("rstresp_busy", busy, 1'b0);
    chk("rstresp_regs", regs_flat, mdl_flat());
    chk_counters("rstresp");
    rst = 1'b0;
    step();
    chk("post_rst_tx_valid", tx_valid, 1'b0);

    // Saturation at 2^CNT_W-1, then clear coincident with an increment
    for (int i = 0; i < 5; i++) run_frame(16'h5000 | 16'(i), "sat");
    chk("sat_value", sig_err_cnt, 2'd3);
    run_frame(16'h6F00, "sat_rng");
    send(16'h5123);
    clr_stat = 1'b1;
    step();
    clr_stat = 1'b0;
    e_sig = '0; e_rng = '0; e_drop = '0;
    chk("clr_err_pulse", frame_err, 1'b1);
    chk_counters("clr");
    step();
    chk_counters("clr_after");

    chk("sb_drained", exp_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/spi_regfile.md
# spi_regfile

Parametrised SPI-slave register file: consumes completed SPI frames (`rx_done` + `rx_data`) from the SPI receiver, validates a signature field, and performs register writes or read-backs on a bank of `NUM_REGS` registers. Read responses are returned as a full frame over a valid/ready handshake to the SPI transmit path. Saturating error/drop counters provide link diagnostics. Sits between the SPI shift-register front end and the fabric logic consuming configuration registers.

## Interface
- `SIG_W`, 4, signature field width
- `SIG_WR`, 4'b0110, signature selecting a write
- `SIG_RD`, 4'b0111, signature selecting a read
- `ADDR_W`, 4, address field width
- `DATA_W`, 8, data field width
- `NUM_REGS`, 16, implemented registers; 1 ≤ NUM_REGS ≤ 2^ADDR_W
- `RESET_VAL`, 0, reset value of every register (DATA_W bits)
- `CNT_W`, 8, diagnostic counter width
- Derived: `FRAME_W = SIG_W+ADDR_W+DATA_W` (16 by default); frame = {sig, addr, data}, MSB first

Ports:
- `clk` in 1: single clock
- `rst` in 1: reset; synchronous and active-high
- `rx_done` in 1: one-cycle pulse, `rx_data` valid this cycle
- `rx_data` in FRAME_W: received frame
- `regs_flat` out NUM_REGS*DATA_W: register i at bits [i*DATA_W +: DATA_W]
- `wr_stb` out NUM_REGS: one-hot, one-cycle pulse on register update
- `frame_ok` out 1: one-cycle pulse, frame accepted
- `frame_err` out 1: one-cycle pulse, frame rejected (signature or range)
- `tx_data` out FRAME_W: read response {SIG_RD, addr, value}
- `tx_valid` out 1: response valid
- `tx_ready` in 1: consumer accepts response
- `busy` out 1: high in any state other than IDLE
- `clr_stat` in 1: synchronous clear of all counters
- `sig_err_cnt`, `range_err_cnt`, `drop_cnt` out CNT_W each: saturating counters

## Operation
- FSM states: IDLE, DECODE, RESP.
- IDLE: `rx_done` captures `rx_data` into frame register → DECODE.
- DECODE (one cycle): sig == SIG_WR and addr < NUM_REGS → write register, pulse `wr_stb[addr]`, `frame_ok` → IDLE. sig == SIG_RD and addr < NUM_REGS → load `tx_data`={SIG_RD, addr, reg[addr]}, assert `tx_valid`, pulse `frame_ok` → RESP. Any other sig → `frame_err`, increment `sig_err_cnt` → IDLE. Valid sig with addr ≥ NUM_REGS → `frame_err`, increment `range_err_cnt`, no write/strobe; for reads `tx_data`={SIG_RD, addr, 0}, `tx_valid` asserted → RESP; writes → IDLE. Data field of reads is ignored.
- RESP: `tx_data`/`tx_valid` held stable until `tx_valid && tx_ready` → deassert next cycle → IDLE.
- `rx_done` in DECODE or RESP: frame discarded, `drop_cnt` incremented; frame register untouched.
- Counters saturate at 2^CNT_W−1. `clr_stat` same cycle as an increment: clear wins, event not counted.
- Reset: all registers = RESET_VAL; `wr_stb`, `frame_ok`, `frame_err`, `tx_valid`, `busy`, counters, `tx_data` = 0; state IDLE. Reset mid-RESP abandons the response (no `tx_valid` after reset).

## Timing
- `rx_done` at cycle N → DECODE in N+1 → effects registered, visible at N+2: `regs_flat` updated, `wr_stb`/`frame_ok`/`frame_err` high for exactly cycle N+2, `tx_valid` rises at N+2, counters update at N+2.
- `busy` high N+1 through the cycle before IDLE return; minimum frame spacing without drops: 2 cycles (write/error), response-completion + 1 (read).
- `tx_ready` with `tx_valid` at cycle M → `tx_valid` low at M+1; `rx_done` at M+1 is accepted.
- `tx_ready` while `tx_valid` low has no effect.

## Structure
- Package `spi_regfile_pkg`: FSM state enum, default signature constants, frame field-extract functions (sig/addr/data) parametrised by widths.
- Sub-module `spi_sat_cnt` (CNT_W, inc, clr, value), instanced three times.

## Test plan
- Write: `rx_data`=16'h63A5 at N → reg3=8'hA5, `wr_stb`=16'h0008 and `frame_ok` exactly at N+2, other registers unchanged.
- Read-back: after above, 16'h7300, `tx_ready` low 5 cycles then high → `tx_data`=16'h73A5 stable, `tx_valid` high from N+2 until cycle after handshake.
- Bad signature: 16'h51FF → no register change, no `wr_stb`, `frame_err` at N+2, `sig_err_cnt`=1.
- Range: NUM_REGS=12, 16'h6E11 and 16'h7E00 → no write, `range_err_cnt`=2, read returns `tx_data`=16'h7E00.
- Drop/reset: `rx_done` during RESP → `drop_cnt`=1, pending response unchanged; `rst` asserted in RESP → `tx_valid`=0, registers=RESET_VAL, state IDLE.
- Saturation/clear: CNT_W=2, five bad frames → `sig_err_cnt`=3; `clr_stat` coincident with sixth bad frame → 0.
